// File: rtl/matmul_pkg.sv
// ---- matmul_pkg : shared FSM encoding and width helpers for matmul_engine ----
// ---- rev 1.0 ----------------------------------------------------------------
`default_nettype none

package matmul_pkg;

    typedef enum logic [3:0] {
        S_IDLE  = 4'b0001,
        S_RUN   = 4'b0010,
        S_DRAIN = 4'b0100,
        S_DONE  = 4'b1000
    } state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    function automatic int clog2_min1(input int v);
        int r;
        r = clog2(v);
        return (r < 1) ? 1 : r;
    endfunction

    // Headroom for summing K full-scale products without wrap-around.
    function automatic int acc_width(input int w, input int k);
        return 2 * w + clog2(k);
    endfunction

endpackage

`default_nettype wire

// File: rtl/matmul_mac_pipe.sv
// ---- mac_pipe : product register, accumulator and scale/saturate stage -----
// ---- rev 1.0 ----------------------------------------------------------------
`default_nettype none

module mac_pipe #(
    parameter int WIDTH      = 8,
    parameter int ACC_W      = 18,
    parameter int IDX_W      = 1,
    parameter int FRAC_SHIFT = 8,
    parameter int SATURATE   = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_valid,
    input  logic             i_first,
    input  logic             i_last,
    input  logic [IDX_W-1:0] i_idx,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_wr_en,
    output logic [IDX_W-1:0] o_wr_addr,
    output logic [WIDTH-1:0] o_wr_data
);

    localparam logic [ACC_W-1:0] c_MAX = {{(ACC_W-WIDTH){1'b0}}, {WIDTH{1'b1}}};

    logic               r_v1, r_f1, r_l1;
    logic [IDX_W-1:0]   r_idx1;
    logic               r_v2, r_f2, r_l2;
    logic [IDX_W-1:0]   r_idx2;
    logic [2*WIDTH-1:0] r_prod;
    logic [ACC_W-1:0]   r_acc;

    logic [ACC_W-1:0]   w_sum;
    logic [ACC_W-1:0]   w_shift;
    logic [WIDTH-1:0]   w_scaled;

    // First-k discards the previous dot product, so no bubble is needed between results.
    always_comb begin
        w_sum    = (r_f2 ? '0 : r_acc) + ACC_W'(r_prod);
        w_shift  = w_sum >> FRAC_SHIFT;
        w_scaled = w_shift[WIDTH-1:0];
        if ((SATURATE != 0) && (w_shift > c_MAX)) w_scaled = '1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1      <= 1'b0;
            r_f1      <= 1'b0;
            r_l1      <= 1'b0;
            r_idx1    <= '0;
            r_v2      <= 1'b0;
            r_f2      <= 1'b0;
            r_l2      <= 1'b0;
            r_idx2    <= '0;
            r_prod    <= '0;
            r_acc     <= '0;
            o_wr_en   <= 1'b0;
            o_wr_addr <= '0;
            o_wr_data <= '0;
        end else begin
            r_v1   <= i_valid;
            r_f1   <= i_first;
            r_l1   <= i_last;
            r_idx1 <= i_idx;

            r_v2   <= r_v1;
            r_f2   <= r_f1;
            r_l2   <= r_l1;
            r_idx2 <= r_idx1;
            r_prod <= {{WIDTH{1'b0}}, i_a} * {{WIDTH{1'b0}}, i_b};

            if (r_v2) r_acc <= w_sum;
            o_wr_en <= r_v2 && r_l2;
            if (r_v2 && r_l2) begin
                o_wr_addr <= r_idx2;
                o_wr_data <= w_scaled;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/matmul_engine.sv
// ---- matmul_engine : pipelined RES = (A x B) >> FRAC_SHIFT over three RAMs --
// ---- rev 1.0 ----------------------------------------------------------------
`default_nettype none

module matmul_engine
    import matmul_pkg::*;
#(
    parameter int width      = 8,
    parameter int A_ROWS     = 2,
    parameter int A_COLS     = 4,
    parameter int B_COLS     = 1,
    parameter int FRAC_SHIFT = 8,
    parameter int SATURATE   = 0,
    localparam int A_DEPTH_BITS   = clog2_min1(A_ROWS * A_COLS),
    localparam int B_DEPTH_BITS   = clog2_min1(A_COLS * B_COLS),
    localparam int RES_DEPTH_BITS = clog2_min1(A_ROWS * B_COLS)
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      Start,
    output logic                      Busy,
    output logic                      Done,
    output logic                      A_read_en,
    output logic [A_DEPTH_BITS-1:0]   A_read_address,
    input  logic [width-1:0]          A_read_data_out,
    output logic                      B_read_en,
    output logic [B_DEPTH_BITS-1:0]   B_read_address,
    input  logic [width-1:0]          B_read_data_out,
    output logic                      RES_write_en,
    output logic [RES_DEPTH_BITS-1:0] RES_write_address,
    output logic [width-1:0]          RES_write_data_in
);

    localparam int ACC_WIDTH = acc_width(width, A_COLS);
    localparam int RW = clog2_min1(A_ROWS);
    localparam int NW = clog2_min1(B_COLS);
    localparam int KW = clog2_min1(A_COLS);

    localparam logic [RW-1:0] c_R_LAST     = RW'(A_ROWS - 1);
    localparam logic [NW-1:0] c_N_LAST     = NW'(B_COLS - 1);
    localparam logic [KW-1:0] c_K_LAST     = KW'(A_COLS - 1);
    localparam logic [1:0]    c_DRAIN_LAST = 2'd2;

    state_t                    r_state;
    logic [1:0]                r_drain;
    logic [RW-1:0]             r_r;
    logic [NW-1:0]             r_n;
    logic [KW-1:0]             r_k;
    logic                      r_rd_en;
    logic                      r_first;
    logic                      r_last;
    logic [RES_DEPTH_BITS-1:0] r_idx;

    logic                      w_start;
    logic                      w_slot_last;
    logic [RW-1:0]             w_r_nxt;
    logic [NW-1:0]             w_n_nxt;
    logic [KW-1:0]             w_k_nxt;
    logic [A_DEPTH_BITS-1:0]   w_a_addr;
    logic [B_DEPTH_BITS-1:0]   w_b_addr;
    logic [RES_DEPTH_BITS-1:0] w_idx;

    // DONE accepts Start too, so a held Start chains runs without an idle cycle.
    always_comb begin
        w_start     = Start && ((r_state == S_IDLE) || (r_state == S_DONE));
        w_slot_last = (r_k == c_K_LAST) && (r_n == c_N_LAST) && (r_r == c_R_LAST);
        w_r_nxt     = r_r;
        w_n_nxt     = r_n;
        w_k_nxt     = r_k;
        if (w_start) begin
            w_r_nxt = '0;
            w_n_nxt = '0;
            w_k_nxt = '0;
        end else if (r_k == c_K_LAST) begin
            w_k_nxt = '0;
            if (r_n == c_N_LAST) begin
                w_n_nxt = '0;
                w_r_nxt = r_r + RW'(1);
            end else begin
                w_n_nxt = r_n + NW'(1);
            end
        end else begin
            w_k_nxt = r_k + KW'(1);
        end
        w_a_addr = A_DEPTH_BITS'(int'(w_r_nxt) * A_COLS + int'(w_k_nxt));
        w_b_addr = B_DEPTH_BITS'(int'(w_k_nxt) * B_COLS + int'(w_n_nxt));
        w_idx    = RES_DEPTH_BITS'(int'(w_r_nxt) * B_COLS + int'(w_n_nxt));
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state        <= S_IDLE;
            r_drain        <= '0;
            r_r            <= '0;
            r_n            <= '0;
            r_k            <= '0;
            r_rd_en        <= 1'b0;
            r_first        <= 1'b0;
            r_last         <= 1'b0;
            r_idx          <= '0;
            A_read_address <= '0;
            B_read_address <= '0;
            Busy           <= 1'b0;
            Done           <= 1'b0;
        end else if (w_start || ((r_state == S_RUN) && !w_slot_last)) begin
            r_state        <= S_RUN;
            Busy           <= 1'b1;
            Done           <= 1'b0;
            r_rd_en        <= 1'b1;
            r_r            <= w_r_nxt;
            r_n            <= w_n_nxt;
            r_k            <= w_k_nxt;
            r_first        <= (w_k_nxt == '0);
            r_last         <= (w_k_nxt == c_K_LAST);
            r_idx          <= w_idx;
            A_read_address <= w_a_addr;
            B_read_address <= w_b_addr;
        end else begin
            case (r_state)
                S_IDLE: begin
                    Busy <= 1'b0;
                    Done <= 1'b0;
                end
                S_RUN: begin
                    r_state <= S_DRAIN;
                    r_rd_en <= 1'b0;
                    r_drain <= '0;
                end
                // Three cycles cover the RAM read, product and accumulate stages.
                S_DRAIN: begin
                    if (r_drain == c_DRAIN_LAST) begin
                        r_state <= S_DONE;
                        Done    <= 1'b1;
                    end else begin
                        r_drain <= r_drain + 2'd1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    Done    <= 1'b0;
                    Busy    <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_rd_en <= 1'b0;
                    Done    <= 1'b0;
                    Busy    <= 1'b0;
                end
            endcase
        end
    end

    assign A_read_en = r_rd_en;
    assign B_read_en = r_rd_en;

    mac_pipe #(
        .WIDTH      (width),
        .ACC_W      (ACC_WIDTH),
        .IDX_W      (RES_DEPTH_BITS),
        .FRAC_SHIFT (FRAC_SHIFT),
        .SATURATE   (SATURATE)
    ) u_mac_pipe (
        .clk       (clk),
        .rst_n     (resetn),
        .i_valid   (r_rd_en),
        .i_first   (r_first),
        .i_last    (r_last),
        .i_idx     (r_idx),
        .i_a       (A_read_data_out),
        .i_b       (B_read_data_out),
        .o_wr_en   (RES_write_en),
        .o_wr_addr (RES_write_address),
        .o_wr_data (RES_write_data_in)
    );

endmodule

`default_nettype wire

// File: tb/tb_matmul_engine.sv
// ---- tb_matmul_engine : four engine configurations against a matrix model ---
// ---- rev 1.0 ----------------------------------------------------------------
`default_nettype none

module tb_matmul_engine;

    localparam int CR  [4] = '{2, 2, 2, 4};
    localparam int CK  [4] = '{4, 4, 3, 1};
    localparam int CN  [4] = '{1, 1, 2, 1};
    localparam int CSH [4] = '{8, 8, 0, 0};
    localparam int CSAT[4] = '{0, 1, 0, 0};

    logic       clk = 1'b0;
    logic       resetn;
    logic [3:0] st;

    logic       busy0, done0, aen0, ben0, wen0;
    logic [2:0] aaddr0;
    logic [1:0] baddr0;
    logic [0:0] waddr0;
    logic [7:0] aq0, bq0, wdata0;

    logic       busy1, done1, aen1, ben1, wen1;
    logic [2:0] aaddr1;
    logic [1:0] baddr1;
    logic [0:0] waddr1;
    logic [7:0] aq1, bq1, wdata1;

    logic       busy2, done2, aen2, ben2, wen2;
    logic [2:0] aaddr2;
    logic [2:0] baddr2;
    logic [1:0] waddr2;
    logic [7:0] aq2, bq2, wdata2;

    logic       busy3, done3, aen3, ben3, wen3;
    logic [1:0] aaddr3;
    logic [0:0] baddr3;
    logic [1:0] waddr3;
    logic [7:0] aq3, bq3, wdata3;

    logic [7:0] ma [4][16];
    logic [7:0] mb [4][16];

    int ecount = 0;
    int base [4];
    int lbase[4] = '{-1, -1, -1, -1};
    bit hb [4][64];
    bit he [4][64];
    bit hw [4][64];
    bit hd [4][64];
    int wr_n   [4];
    int wr_addr[4][16];
    int wr_data[4][16];
    int wr_cyc [4][16];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) ecount++;

    matmul_engine #(.width(8), .A_ROWS(2), .A_COLS(4), .B_COLS(1), .FRAC_SHIFT(8), .SATURATE(0)) u_dut0 (
        .clk(clk), .resetn(resetn), .Start(st[0]), .Busy(busy0), .Done(done0),
        .A_read_en(aen0), .A_read_address(aaddr0), .A_read_data_out(aq0),
        .B_read_en(ben0), .B_read_address(baddr0), .B_read_data_out(bq0),
        .RES_write_en(wen0), .RES_write_address(waddr0), .RES_write_data_in(wdata0));

    matmul_engine #(.width(8), .A_ROWS(2), .A_COLS(4), .B_COLS(1), .FRAC_SHIFT(8), .SATURATE(1)) u_dut1 (
        .clk(clk), .resetn(resetn), .Start(st[1]), .Busy(busy1), .Done(done1),
        .A_read_en(aen1), .A_read_address(aaddr1), .A_read_data_out(aq1),
        .B_read_en(ben1), .B_read_address(baddr1), .B_read_data_out(bq1),
        .RES_write_en(wen1), .RES_write_address(waddr1), .RES_write_data_in(wdata1));

    matmul_engine #(.width(8), .A_ROWS(2), .A_COLS(3), .B_COLS(2), .FRAC_SHIFT(0), .SATURATE(0)) u_dut2 (
        .clk(clk), .resetn(resetn), .Start(st[2]), .Busy(busy2), .Done(done2),
        .A_read_en(aen2), .A_read_address(aaddr2), .A_read_data_out(aq2),
        .B_read_en(ben2), .B_read_address(baddr2), .B_read_data_out(bq2),
        .RES_write_en(wen2), .RES_write_address(waddr2), .RES_write_data_in(wdata2));

    matmul_engine #(.width(8), .A_ROWS(4), .A_COLS(1), .B_COLS(1), .FRAC_SHIFT(0), .SATURATE(0)) u_dut3 (
        .clk(clk), .resetn(resetn), .Start(st[3]), .Busy(busy3), .Done(done3),
        .A_read_en(aen3), .A_read_address(aaddr3), .A_read_data_out(aq3),
        .B_read_en(ben3), .B_read_address(baddr3), .B_read_data_out(bq3),
        .RES_write_en(wen3), .RES_write_address(waddr3), .RES_write_data_in(wdata3));

    // Synchronous RAM models: one-cycle read latency.
    always @(posedge clk) begin
        if (aen0) aq0 <= ma[0][aaddr0];
        if (ben0) bq0 <= mb[0][baddr0];
        if (aen1) aq1 <= ma[1][aaddr1];
        if (ben1) bq1 <= mb[1][baddr1];
        if (aen2) aq2 <= ma[2][aaddr2];
        if (ben2) bq2 <= mb[2][baddr2];
        if (aen3) aq3 <= ma[3][aaddr3];
        if (ben3) bq3 <= mb[3][baddr3];
    end

    task automatic mon(int i, logic busy, logic en, logic wen, logic done, int wa, int wd);
        int c;
        if (base[i] != lbase[i]) begin
            lbase[i] = base[i];
            wr_n[i]  = 0;
            for (int j = 0; j < 64; j++) begin
                hb[i][j] = 1'b0;
                he[i][j] = 1'b0;
                hw[i][j] = 1'b0;
                hd[i][j] = 1'b0;
            end
        end
        c = ecount - base[i];
        if (c >= 0 && c < 64) begin
            hb[i][c] = busy;
            he[i][c] = en;
            hw[i][c] = wen;
            hd[i][c] = done;
        end
        if (wen && wr_n[i] < 16) begin
            wr_addr[i][wr_n[i]] = wa;
            wr_data[i][wr_n[i]] = wd;
            wr_cyc[i][wr_n[i]]  = c;
            wr_n[i]++;
        end
    endtask

    always @(negedge clk) begin
        mon(0, busy0, aen0 && ben0, wen0, done0, int'(waddr0), int'(wdata0));
        mon(1, busy1, aen1 && ben1, wen1, done1, int'(waddr1), int'(wdata1));
        mon(2, busy2, aen2 && ben2, wen2, done2, int'(waddr2), int'(wdata2));
        mon(3, busy3, aen3 && ben3, wen3, done3, int'(waddr3), int'(wdata3));
    end

    task automatic chk(string tag, int obs, int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // RES[r][n] = (sum_k A[r][k]*B[k][n]) >> shift, then clamp or keep the low byte.
    function automatic int ref_res(int i, int r, int n);
        int sum, s;
        sum = 0;
        for (int k = 0; k < CK[i]; k++)
            sum += int'(ma[i][r * CK[i] + k]) * int'(mb[i][k * CN[i] + n]);
        s = sum >> CSH[i];
        if (CSAT[i] != 0 && s > 255) return 255;
        return s % 256;
    endfunction

    task automatic fill(int i, int va, int vb);
        for (int j = 0; j < 16; j++) begin
            ma[i][j] = 8'(va);
            mb[i][j] = 8'(vb);
        end
    endtask

    task automatic randfill(int i);
        for (int j = 0; j < 16; j++) begin
            ma[i][j] = 8'($urandom_range(0, 255));
            mb[i][j] = 8'($urandom_range(0, 255));
        end
    endtask

    task automatic kick(int i);
        @(posedge clk);
        #1;
        base[i] = ecount;
        st[i]   = 1'b1;
        @(posedge clk);
        #1;
        st[i]   = 1'b0;
    endtask

    task automatic check_run(int i, string tag);
        int t, bad;
        t = CR[i] * CK[i] * CN[i];
        chk($sformatf("%s_nwr", tag), wr_n[i], CR[i] * CN[i]);
        for (int j = 0; j < CR[i] * CN[i] && j < wr_n[i]; j++) begin
            chk($sformatf("%s_addr%0d", tag, j), wr_addr[i][j], j);
            chk($sformatf("%s_data%0d", tag, j), wr_data[i][j], ref_res(i, j / CN[i], j % CN[i]));
            chk($sformatf("%s_cyc%0d", tag, j), wr_cyc[i][j], 3 + CK[i] * (j + 1));
        end
        bad = 0;
        for (int c = 0; c < 64; c++) begin
            if (hb[i][c] != (c >= 1 && c <= t + 4)) bad++;
            if (he[i][c] != (c >= 1 && c <= t)) bad++;
            if (hd[i][c] != (c == t + 4)) bad++;
        end
        chk($sformatf("%s_timing", tag), bad, 0);
    endtask

    task automatic run_std(int i, string tag);
        kick(i);
        repeat (24) @(posedge clk);
        #1;
        check_run(i, tag);
    endtask

    initial begin
        resetn = 1'b0;
        st     = 4'b0;
        for (int i = 0; i < 4; i++) begin
            base[i] = 0;
            fill(i, 0, 0);
        end
        @(posedge clk);
        #1;
        chk("reset_ctrl", int'({busy0, done0, aen0, ben0, wen0}), 0);
        chk("reset_addr", int'(aaddr0) + int'(baddr0) + int'(waddr0) + int'(wdata0), 0);
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;

        fill(0, 16, 16);
        run_std(0, "s16");
        chk("s16_res0", wr_data[0][0], 4);
        chk("s16_res1", wr_data[0][1], 4);

        fill(0, 255, 255);
        run_std(0, "trunc");
        chk("trunc_res0", wr_data[0][0], 248);
        fill(1, 255, 255);
        run_std(1, "sat");
        chk("sat_res0", wr_data[1][0], 255);

        for (int j = 0; j < 6; j++) begin
            ma[2][j] = 8'(j + 1);
            mb[2][j] = 8'(j + 1);
        end
        run_std(2, "m232");
        chk("m232_r0", wr_data[2][0], 22);
        chk("m232_r1", wr_data[2][1], 28);
        chk("m232_r2", wr_data[2][2], 49);
        chk("m232_r3", wr_data[2][3], 64);

        for (int j = 0; j < 4; j++) ma[3][j] = 8'(j + 1);
        mb[3][0] = 8'd10;
        run_std(3, "k1");
        chk("k1_r3", wr_data[3][3], 40);

        for (int rep = 0; rep < 3; rep++) begin
            for (int i = 0; i < 4; i++) begin
                randfill(i);
                run_std(i, $sformatf("rnd%0d_%0d", rep, i));
            end
        end

        randfill(0);
        kick(0);
        repeat (4) @(posedge clk);
        #1;
        st[0] = 1'b1;
        @(posedge clk);
        #1;
        st[0] = 1'b0;
        repeat (22) @(posedge clk);
        #1;
        check_run(0, "busy_start");

        randfill(0);
        @(posedge clk);
        #1;
        base[0] = ecount;
        st[0]   = 1'b1;
        repeat (14) @(posedge clk);
        #1;
        st[0]   = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        chk("cont_nwr", wr_n[0], 4);
        chk("cont_gap12", int'(he[0][12]), 0);
        chk("cont_issue13", int'(he[0][13]), 1);
        chk("cont_done12", int'(hd[0][12]), 1);
        chk("cont_busy13", int'(hb[0][13]), 1);
        chk("cont_done24", int'(hd[0][24]), 1);
        chk("cont_wcyc19", wr_cyc[0][2], 19);
        chk("cont_data2", wr_data[0][2], ref_res(0, 0, 0));
        chk("cont_stop25", int'(hb[0][25]), 0);

        randfill(0);
        kick(0);
        repeat (5) @(posedge clk);
        #1;
        resetn = 1'b0;
        #1;
        chk("arst_ctrl", int'({busy0, done0, aen0, ben0, wen0}), 0);
        chk("arst_addr", int'(aaddr0) + int'(baddr0) + int'(waddr0) + int'(wdata0), 0);
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        chk("arst_nwr", wr_n[0], 0);
        chk("arst_wen7", int'(hw[0][7]), 0);
        chk("arst_idle", int'(hb[0][12]), 0);

        fill(0, 16, 16);
        run_std(0, "post_rst");
        chk("post_rst_res1", wr_data[0][1], 4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
